// File: rtl/vga_scan_seq.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_seq
//  Brief    : 640x480@60 VGA raster counters and sync generation, plus an
//             LFSR-driven one-hot lane sequencer for the falling-tile pattern.
//  Revision : 1.0  initial release
// ============================================================================
module vga_scan_seq #(
    parameter int         H_ACTIVE       = 640,
    parameter int         H_FP           = 16,
    parameter int         H_SYNC         = 96,
    parameter int         H_BP           = 48,
    parameter int         V_ACTIVE       = 480,
    parameter int         V_FP           = 10,
    parameter int         V_SYNC         = 2,
    parameter int         V_BP           = 33,
    parameter int         FRAMES_PER_ROW = 60,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic       clk_d,
    input  logic       rst_n,
    input  logic       run,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       active,
    output logic       frame_tick,
    output logic [3:0] state,
    output logic       st_chng
);

    localparam int         H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS     = 10'(H_ACTIVE);
    localparam logic [9:0] Y_VIS     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [15:0] FCNT_LAST = 16'(FRAMES_PER_ROW - 1);

    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic [7:0]  lfsr;
    logic [7:0]  next_lfsr;
    logic [15:0] fcnt;
    logic        run_prev;
    logic [1:0]  cur_lane;
    logic [1:0]  new_lane;
    logic        row_due;

    // Next raster position: x wraps every line, y advances on the x wrap.
    always_comb begin
        next_x = pixel_x + 10'd1;
        next_y = pixel_y;
        if (pixel_x == X_LAST) begin
            next_x = '0;
            next_y = (pixel_y == Y_LAST) ? '0 : pixel_y + 10'd1;
        end
    end

    // Raster counters; decoded outputs are built from the next position so
    // they line up with the counters in the same cycle.
    always_ff @(posedge clk_d) begin
        if (!rst_n) begin
            pixel_x    <= X_LAST;
            pixel_y    <= Y_LAST;
            active     <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            pixel_x    <= next_x;
            pixel_y    <= next_y;
            active     <= (next_x < X_VIS) && (next_y < Y_VIS);
            hsync      <= !((next_x >= HS_FIRST) && (next_x <= HS_LAST));
            vsync      <= !((next_y >= VS_FIRST) && (next_y <= VS_LAST));
            frame_tick <= (next_x == X_LAST) && (next_y == Y_LAST);
        end
    end

    // Lane choice: LFSR low bits, bumped by one if it would repeat the
    // current lane. A frame_tick only counts if run was already high on the
    // previous edge, so a tick coinciding with run rising is ignored.
    always_comb begin
        next_lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        cur_lane  = 2'd0;
        case (state)
            4'b0010: cur_lane = 2'd1;
            4'b0100: cur_lane = 2'd2;
            4'b1000: cur_lane = 2'd3;
            default: cur_lane = 2'd0;
        endcase
        new_lane = next_lfsr[1:0];
        if (new_lane == cur_lane) begin
            new_lane = new_lane + 2'd1;
        end
        row_due = run && run_prev && frame_tick && (fcnt == FCNT_LAST);
    end

    // Frame counter, LFSR and lane register; run low freezes the pattern.
    always_ff @(posedge clk_d) begin
        if (!rst_n) begin
            lfsr     <= LFSR_SEED;
            fcnt     <= '0;
            run_prev <= 1'b0;
            state    <= 4'b0001;
            st_chng  <= 1'b0;
        end else begin
            run_prev <= run;
            st_chng  <= 1'b0;
            if (!run) begin
                fcnt <= '0;
            end else if (frame_tick) begin
                if (!run_prev || (fcnt == FCNT_LAST)) begin
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + 16'd1;
                end
            end
            if (row_due) begin
                lfsr    <= next_lfsr;
                state   <= 4'b0001 << new_lane;
                st_chng <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/vga_scan_seq.md
# vga_scan_seq

- Generates the 640x480 at 60 Hz VGA raster for the piano-tiles display from the 25 MHz pixel clock.
- Drives the pixel generator's `pixel_x`, `pixel_y` and `active` inputs, plus the board `hsync`/`vsync` pins.
- Also sequences the falling-tile lane pattern (`state`, `st_chng`) once every `FRAMES_PER_ROW` frames using an LFSR, so the pixel generator receives its whole scan and pattern context from one source.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch
- `FRAMES_PER_ROW`, 60, frames between lane-pattern changes (>=1)
- `LFSR_SEED`, 8'hA5, LFSR reset value (nonzero)

Ports:
- `clk_d` in 1: pixel clock, 25 MHz. One clock; reset is synchronous and active-low.
- `rst_n` in 1: synchronous active-low reset
- `run` in 1: enables the lane sequencer (high while the game is playing)
- `hsync` out 1: horizontal sync, active-low
- `vsync` out 1: vertical sync, active-low
- `pixel_x` out 10: current column, 0..799
- `pixel_y` out 10: current line, 0..524
- `active` out 1: high when the current position is visible
- `frame_tick` out 1: one-cycle pulse at the last position of the frame
- `state` out 4: one-hot active lane for the pixel generator
- `st_chng` out 1: one-cycle pulse when `state` changes

## Operation
Raster:
- Line total is 800 (`H_ACTIVE+H_FP+H_SYNC+H_BP`); frame total is 525 lines.
- `pixel_x` and `pixel_y` are the counter registers themselves.
- `pixel_x` increments every cycle and wraps 799->0. `pixel_y` increments on that wrap and wraps 524->0.
- `active`, `hsync`, `vsync` and `frame_tick` are registered from the next-count values, so all outputs describe the same (x,y) in the same cycle.
- `active` = (x<640)&&(y<480).
- `hsync` = 0 iff 656<=x<=751.
- `vsync` = 0 iff 490<=y<=491, for the full lines.
- `frame_tick` = 1 iff (x,y)=(799,524).

Lane sequencer:
- `lfsr` is 8 bits, Fibonacci, shifting left. Next value is `{lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
- `fcnt` counts `frame_tick`s while `run`=1.
- On a `frame_tick` with `fcnt`==`FRAMES_PER_ROW-1`:
  - `fcnt` returns to 0 and `lfsr` advances.
  - The lane is `next_lfsr[1:0]`. If that equals the current lane, the lane becomes lane+1 mod 4, so there are never two consecutive identical lanes.
  - `state` <= one-hot(lane) and `st_chng` pulses. Both update on the same edge, so the pulse coincides with position (0,0) of the new frame.
- `run`=0: `fcnt` is held at 0, `lfsr` and `state` are held, `st_chng`=0. The first change after `run` rises therefore comes `FRAMES_PER_ROW` frame_ticks later.

Reset values (every output while `rst_n`=0):
- `pixel_x`=799, `pixel_y`=524
- `active`=0, `hsync`=1, `vsync`=1
- `frame_tick`=0 (it is forced low during reset, even though the reset position is (799,524))
- `state`=4'b0001, `st_chng`=0
- Internally: `lfsr`=`LFSR_SEED`, `fcnt`=0

## Timing
- The first edge with `rst_n`=1 yields (0,0) with `active`=1.
- Frame period is 420000 cycles. `frame_tick` fires at cycle 419999 relative to (0,0).
- Each line has `active` high for 640 cycles and `hsync` low for 96 cycles, starting when `pixel_x`=656.
- `vsync` is low for 1600 consecutive cycles, starting at (0,490).
- Reset mid-frame: all outputs take their reset values on the next edge. The counters do not resume the old position.
- Simultaneous events:
  - `frame_tick` together with `run` falling in the same cycle: `run` is sampled on that edge and takes priority, so no change happens and `fcnt` clears.
  - `run` rising on the same edge as a `frame_tick`: `fcnt` goes to 0.
- All outputs are registered, and no output is a combinational function of an input.

## Test plan
- Reset for 3 cycles, then release -> `pixel_x`/`pixel_y` = 799/524 during reset with `active`=0. The first released cycle gives (0,0), `active`=1, `state`=0001.
- Run 800 cycles -> `active` high for exactly 640 cycles. `hsync` low for exactly 96 cycles, at `pixel_x` 656..751. `pixel_y` goes 0->1 at the wrap.
- Run 2 frames -> `frame_tick` at cycles 419999 and 839999 only. `vsync` low for 1600 cycles, starting at (0,490).
- `FRAMES_PER_ROW`=2, seed A5, `run`=1 -> `lfsr` goes to 4A and `state`=0100 with `st_chng` at the 2nd frame_tick edge. After 2 more frame_ticks: `lfsr`=95, `state`=0010.
- `run`=0 for 5 frames, then 1 -> no `st_chng` while low. The first change comes 2 frame_ticks after `run` rises.
- Assert `rst_n` at (300,200) for 1 cycle -> reset values appear on the next edge, then (0,0) follows. `state` returns to 0001.
